// File: rtl/iis_pkg.sv
// iis_pkg: shared types and constants for the I2S receive path.
// Holds the receiver FSM state enum, default word width, channel codes.
package iis_pkg;

  localparam int DATA_W_DEF = 16;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_SHIFT,
    ST_PUSH
  } rx_state_e;

endpackage

// File: rtl/iis_rx_fifo.sv
// iis_rx_fifo: synchronous show-ahead FIFO, DEPTH a power of two.
// Ports: sck/rst clock and async active-low reset; wr_en/wr_data push;
//   rd_en pop; rd_data head word (0 when empty); empty/full/count status.
module iis_rx_fifo #(
  parameter int DW    = 17,
  parameter int DEPTH = 8
) (
  input  logic                     sck,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_data,
  input  logic                     rd_en,
  output logic [DW-1:0]            rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_wr;
  logic          do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO only lands if the head leaves in the same cycle.
  always_comb begin
    do_rd    = rd_en && !empty;
    do_wr    = wr_en && (!full || rd_en);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sck or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge sck) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/iis_rx_deser.sv
// iis_rx_deser: I2S receive deserializer feeding a show-ahead word FIFO.
// Define IIS_RX_OVERFLOW_CNT_EN to add the ovf_cnt dropped-word counter.
// Ports: sck bit clock; rst async active-low reset; en receive enable;
//   ws/sd I2S word select and serial data (MSB first); rd_en FIFO pop;
//   rd_data {chan,word} head; fifo_empty/fifo_full/fifo_count status;
//   recv_num/recv_finish block progress; frame_err sticky abort flag;
//   ovf_cnt saturating dropped-word count (macro builds only).
module iis_rx_deser
  import iis_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int SAMPLE_NUM = 64
) (
  input  logic                         sck,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         ws,
  input  logic                         sd,
  input  logic                         rd_en,
  output logic [DATA_W:0]              rd_data,
  output logic                         fifo_empty,
  output logic                         fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic [31:0]                  recv_num,
  output logic                         recv_finish,
  output logic                         frame_err
`ifdef IIS_RX_OVERFLOW_CNT_EN
  ,
  output logic [15:0]                  ovf_cnt
`endif
);

  localparam int BW = $clog2(DATA_W + 1);

  rx_state_e          state_q, state_d;
  logic               ws_dly_q;
  logic               chan_q, chan_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [31:0]        recv_num_q, recv_num_d;
  logic               frame_err_q, frame_err_d;
  logic               ws_edge;
  logic               push;

  assign ws_edge     = ws ^ ws_dly_q;
  assign push        = en && (state_q == ST_PUSH);
  assign recv_num    = recv_num_q;
  assign recv_finish = (recv_num_q == 32'(SAMPLE_NUM - 1));
  assign frame_err   = frame_err_q;

  // A WS edge marks the slot before the MSB; SKIP absorbs that delay slot.
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    frame_err_d = frame_err_q;
    if (!en) begin
      state_d     = ST_IDLE;
      shreg_d     = '0;
      bit_cnt_d   = '0;
      frame_err_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ws_edge) begin
            state_d = ST_SKIP;
            chan_d  = ws;
          end
        end
        ST_SKIP: begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
        end
        ST_SHIFT: begin
          if (ws_edge) begin
            state_d     = ST_SKIP;
            chan_d      = ws;
            frame_err_d = 1'b1;
            shreg_d     = '0;
            bit_cnt_d   = '0;
          end else begin
            shreg_d   = {shreg_q[DATA_W-2:0], sd};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BW'(DATA_W - 1)) state_d = ST_PUSH;
          end
        end
        ST_PUSH: begin
          if (ws_edge) begin
            state_d = ST_SKIP;
            chan_d  = ws;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Block counter advances on every push, dropped words included.
  always_comb begin
    recv_num_d = recv_num_q;
    if (push) recv_num_d = recv_finish ? '0 : recv_num_q + 32'd1;
  end

  always_ff @(posedge sck or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ws_dly_q    <= 1'b0;
      chan_q      <= CH_LEFT;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      recv_num_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ws_dly_q    <= ws;
      chan_q      <= chan_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      recv_num_q  <= recv_num_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef IIS_RX_OVERFLOW_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;
  logic        drop;

  assign drop    = push && fifo_full && !rd_en;
  assign ovf_cnt = ovf_cnt_q;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop && ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge sck or negedge rst) begin
    if (!rst) ovf_cnt_q <= '0;
    else      ovf_cnt_q <= ovf_cnt_d;
  end
`endif

  iis_rx_fifo #(
    .DW    (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sck     (sck),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({chan_q, shreg_q}),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_iis_rx_deser.sv
// tb_iis_rx_deser: frame-level I2S stimulus against a queue-based model.
// Build with IIS_RX_OVERFLOW_CNT_EN to also check ovf_cnt.
module tb_iis_rx_deser;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int SN    = 64;

  logic          sck = 1'b0;
  logic          rst;
  logic          en;
  logic          ws;
  logic          sd;
  logic          rd_en;
  logic [DW:0]   rd_data;
  logic          fifo_empty;
  logic          fifo_full;
  logic [3:0]    fifo_count;
  logic [31:0]   recv_num;
  logic          recv_finish;
  logic          frame_err;
`ifdef IIS_RX_OVERFLOW_CNT_EN
  logic [15:0]   ovf_cnt;
`endif

  always #5 sck = ~sck;

  iis_rx_deser #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .SAMPLE_NUM (SN)
  ) dut (
    .sck         (sck),
    .rst         (rst),
    .en          (en),
    .ws          (ws),
    .sd          (sd),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .fifo_count  (fifo_count),
    .recv_num    (recv_num),
    .recv_finish (recv_finish),
    .frame_err   (frame_err)
`ifdef IIS_RX_OVERFLOW_CNT_EN
    ,
    .ovf_cnt     (ovf_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Model: received words as a bounded queue plus block and error state.
  logic [DW:0] q[$];
  int          m_recv;
  bit          m_ferr;
`ifdef IIS_RX_OVERFLOW_CNT_EN
  int          m_ovf;
`endif
  bit          cur_ws;
  bit          en_drv;
  bit          pend_push;
  bit          pend_abort;
  logic [DW:0] pend_word;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("fifo_empty", fifo_empty, q.size() == 0);
    chk("fifo_full", fifo_full, q.size() == DEPTH);
    chk("fifo_count", fifo_count, q.size());
    if (q.size() > 0) chk("rd_data", rd_data, q[0]);
    chk("recv_num", recv_num, m_recv);
    chk("recv_finish", recv_finish, m_recv == SN - 1);
    chk("frame_err", frame_err, m_ferr);
`ifdef IIS_RX_OVERFLOW_CNT_EN
    chk("ovf_cnt", ovf_cnt, m_ovf);
`endif
  endtask

  // Effects of one rising edge: pop first, then the word completed
  // in the previous slot is offered to the (possibly just freed) FIFO.
  task automatic model_edge(bit r);
    if (r && q.size() > 0) void'(q.pop_front());
    if (pend_push) begin
      if (q.size() < DEPTH) q.push_back(pend_word);
`ifdef IIS_RX_OVERFLOW_CNT_EN
      else if (m_ovf < 16'hFFFF) m_ovf++;
`endif
      m_recv = (m_recv == SN - 1) ? 0 : m_recv + 1;
    end
    if (pend_abort) m_ferr = 1'b1;
    pend_push  = 1'b0;
    pend_abort = 1'b0;
  endtask

  task automatic slot(bit w, bit d, bit r);
    @(negedge sck);
    check_all();
    en     = en_drv;
    ws     = w;
    sd     = d;
    rd_en  = r;
    cur_ws = w;
    @(posedge sck);
    model_edge(r);
  endtask

  function automatic bit rnd_rd(int p);
    return int'($urandom_range(99)) < p;
  endfunction

  // One channel slot: WS toggle, delay bit, nbits data bits, pad bits.
  // nbits < DW means the next WS toggle will cut the word short.
  task automatic frame(logic [DW-1:0] word, int nbits, int pad, int rdp);
    bit nw = !cur_ws;
    slot(nw, 1'($urandom), rnd_rd(rdp));
    slot(nw, 1'b0, rnd_rd(rdp));
    for (int i = 0; i < nbits; i++)
      slot(nw, word[DW-1-i], rnd_rd(rdp));
    if (nbits == DW) begin
      pend_push = 1'b1;
      pend_word = {nw, word};
    end else begin
      pend_abort = 1'b1;
    end
    for (int i = 0; i < pad; i++)
      slot(nw, 1'($urandom), rnd_rd(rdp));
  endtask

  task automatic drain();
    repeat (DEPTH + 2) slot(cur_ws, 1'($urandom), 1'b1);
  endtask

  task automatic do_reset();
    @(negedge sck);
    #2;
    rst    = 1'b0;
    ws     = 1'b0;
    sd     = 1'b0;
    rd_en  = 1'b0;
    cur_ws = 1'b0;
    q.delete();
    m_recv     = 0;
    m_ferr     = 1'b0;
    pend_push  = 1'b0;
    pend_abort = 1'b0;
`ifdef IIS_RX_OVERFLOW_CNT_EN
    m_ovf = 0;
    #1 chk("rst_ovf_cnt", ovf_cnt, 0);
`else
    #1;
`endif
    chk("rst_fifo_empty", fifo_empty, 1);
    chk("rst_fifo_full", fifo_full, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_recv_num", recv_num, 0);
    chk("rst_recv_finish", recv_finish, 0);
    chk("rst_frame_err", frame_err, 0);
    repeat (2) @(negedge sck);
    rst = 1'b1;
  endtask

  logic [DW:0] exp41 [4];

  initial begin
    rst    = 1'b0;
    en     = 1'b1;
    en_drv = 1'b1;
    ws     = 1'b0;
    sd     = 1'b0;
    rd_en  = 1'b0;
    cur_ws = 1'b0;
    do_reset();

    // Right-channel word after a 0->1 WS edge.
    frame(16'hA5C3, DW, 2, 0);
    #1 chk("a5c3_word", rd_data, 17'h1A5C3);
    drain();

    // Alternating channels, no reads.
    exp41[0] = 17'h01234;
    exp41[1] = 17'h1FEDC;
    exp41[2] = 17'h01234;
    exp41[3] = 17'h1FEDC;
    for (int i = 0; i < 4; i++)
      frame(i[0] ? 16'hFEDC : 16'h1234, DW, 1, 0);
    #1 chk("alt_count", fifo_count, 4);
    for (int i = 0; i < 4; i++) begin
      #1 chk("alt_order", rd_data, exp41[i]);
      slot(cur_ws, 1'b0, 1'b1);
    end

    // Reset while bit 10 is on the wire, then a clean frame.
    frame(16'h5A5A, 10, 0, 0);
    do_reset();
    frame(16'hC35A, DW, 1, 0);
    #1 chk("post_rst_word", rd_data, 17'h1C35A);

    // Overfill from empty: ninth word is dropped.
    do_reset();
    for (int i = 0; i < 9; i++)
      frame(16'h1111 * 16'(i + 1), DW, 1, 0);
    #1 chk("ovf_full", fifo_full, 1);
    chk("ovf_recv_num", recv_num, 9);
    chk("ovf_head", rd_data, 17'h11111);
`ifdef IIS_RX_OVERFLOW_CNT_EN
    chk("ovf_cnt_one", ovf_cnt, 1);
`endif
    drain();

    // Abort after 7 bits, then a full word.
    frame(16'h0F0F, 7, 0, 0);
    frame(16'hBEEF, DW, 1, 0);
    #1 chk("abort_ferr", frame_err, 1);
    chk("abort_word", rd_data, {cur_ws, 16'hBEEF});
    chk("abort_count", fifo_count, 1);

    // Partial word cut by en low: discarded, frame_err cleared.
    frame(16'h1357, 5, 0, 0);
    pend_abort = 1'b0;
    en_drv     = 1'b0;
    slot(cur_ws, 1'b1, 1'b0);
    m_ferr = 1'b0;
    slot(cur_ws, 1'b1, 1'b0);
    #1 chk("en_low_ferr", frame_err, 0);
    chk("en_low_count", fifo_count, 1);
    en_drv = 1'b1;
    frame(16'h2468, DW, 1, 0);
    #1 chk("en_back_count", fifo_count, 2);
    drain();

    // Randomised frames with frequent reads, including aborts.
    for (int n = 0; n < 150; n++) begin
      int nb;
      nb = ($urandom_range(9) == 0 && n != 149)
         ? int'($urandom_range(DW - 1, 1)) : DW;
      frame(16'($urandom), nb,
            (nb == DW) ? int'($urandom_range(3)) : 0, 60);
    end

    // Sparse reads to exercise full, drop and push+pop on full.
    for (int n = 0; n < 40; n++)
      frame(16'($urandom), DW, int'($urandom_range(2)), 8);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
